fmul_rr_arbiter: RTL

- Shares one pipelined single-precision float multiplier core between NUM_REQ requesters, e.g. solver stages of the PV model.
- Round-robin arbitration with at most one issue per clock.
- A tag pipeline tracks request ownership, so each result returns to the requester that issued it.
- Sits between the requesters and the multiplier core; the core is external and connected through the mul_* ports.

---
 rtl/fmul_rr_arbiter.sv | 106 ++++++++++
 1 files changed

// File: rtl/fmul_rr_arbiter.sv
// Round-robin front end sharing one pipelined float multiplier; results return to their issuer.
// Latency gnt->done is MUL_LAT+2 clocks; no stall path, one issue per clock, requesters hold req until granted.
module fmul_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 32,
  parameter int MUL_LAT = 5,
  parameter int IDW     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*DW-1:0] x_bus,
  input  logic [NUM_REQ*DW-1:0] y_bus,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [DW-1:0]         mul_dataa,
  output logic [DW-1:0]         mul_datab,
  output logic                  mul_clk_en,
  input  logic [DW-1:0]         mul_result,
  output logic [DW-1:0]         xy,
  output logic [NUM_REQ-1:0]    done,
  output logic                  busy
);

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

  logic [IDW-1:0]   ptr;
  tag_t [MUL_LAT:0] tag_pipe;
  logic             win_vld;
  logic [IDW-1:0]   win_id;
  logic             issue;
  logic [DW-1:0]    win_x;
  logic [DW-1:0]    win_y;

  // Two passes: indices at or above ptr first, then the wrapped ones below ptr.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_vld && req[k] && (IDW'(k) >= ptr)) begin
        win_vld = 1'b1;
        win_id  = IDW'(k);
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_vld && req[k]) begin
        win_vld = 1'b1;
        win_id  = IDW'(k);
      end
    end
  end

  assign issue      = win_vld & ~rst;
  assign mul_clk_en = ~rst;

  always_comb begin
    gnt   = '0;
    win_x = '0;
    win_y = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      gnt[k] = issue && (win_id == IDW'(k));
      if (gnt[k]) begin
        win_x = x_bus[k*DW +: DW];
        win_y = y_bus[k*DW +: DW];
      end
    end
  end

  always_comb begin
    busy = |done;
    for (int s = 0; s <= MUL_LAT; s++) begin
      busy = busy | tag_pipe[s].vld;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      mul_dataa <= '0;
      mul_datab <= '0;
      tag_pipe  <= '0;
      xy        <= '0;
      done      <= '0;
    end else begin
      tag_pipe[0] <= '{vld: issue, id: win_id};
      for (int s = 1; s <= MUL_LAT; s++) begin
        tag_pipe[s] <= tag_pipe[s-1];
      end
      if (issue) begin
        mul_dataa <= win_x;
        mul_datab <= win_y;
        ptr       <= (win_id == IDW'(NUM_REQ-1)) ? '0 : win_id + IDW'(1);
      end
      // The last tag stage lines up with the core's product for the same op.
      if (tag_pipe[MUL_LAT].vld) begin
        xy <= mul_result;
      end
      for (int k = 0; k < NUM_REQ; k++) begin
        done[k] <= tag_pipe[MUL_LAT].vld && (tag_pipe[MUL_LAT].id == IDW'(k));
      end
    end
  end

endmodule
